pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
Parametrised physical-memory arbiter between NUM_CH line-granular requesters (I-cache, D-cache, victim buffer, ...) and a single physical-memory port. It uses the same read/write/resp handshake as the memory model. It is the successor to the single-requester CPU-to-pmem hookup: each channel is a full pmem-style port, arbitration is round-robin, and the request is latched at grant. It sits between the cache hierarchy and physical_memory inside the top level.

Parameters:
NUM_CH, 2, number of requester channels (2..8)
ADDR_W, 16, physical address width
LINE_W, 128, line (transfer) width in bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ch_read  in  NUM_CH  per-channel line read request, held until ch_resp
ch_write  in  NUM_CH  per-channel line write request, held until ch_resp
ch_address  in  NUM_CH*ADDR_W  per-channel address, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*LINE_W  per-channel write line, channel i at [i*LINE_W +: LINE_W]
ch_resp  out  NUM_CH  one-hot completion strobe to the granted channel
ch_rdata  out  LINE_W  read line, broadcast to all channels, valid when ch_resp[i]=1
pmem_read  out  1  read request to physical memory
pmem_write  out  1  write request to physical memory
pmem_address  out  ADDR_W  latched address of the granted request
pmem_wdata  out  LINE_W  latched write line of the granted request
pmem_resp  in  1  physical memory completion
pmem_rdata  in  LINE_W  physical memory read line

Behaviour:
- Single clock, synchronous active-high reset on clk; rst is sampled only at posedge clk.
- Reset values: state=IDLE, rr_ptr=0, grant=0, op regs=0, pmem_address=0, pmem_wdata=0. Consequently pmem_read=0, pmem_write=0, ch_resp=0.
- Channel i requests when ch_read[i] | ch_write[i]. If both are high, the request is treated as a write; this is illegal for requesters and flagged by a simulation assertion.
- FSM, two states:
  - IDLE: pmem_read/pmem_write are low. If any channel requests, the arbiter selects the first requesting channel at or after rr_ptr, searching upward modulo NUM_CH. At the clock edge it latches grant, op (rd/wr), address and wdata from that channel, then moves to BUSY. If no channel requests, it stays in IDLE.
  - BUSY: pmem_read = op_rd and pmem_write = op_wr, both driven from registers. pmem_address and pmem_wdata are held constant. While pmem_resp=0, the FSM stays in BUSY.
  - BUSY with pmem_resp=1, same cycle: ch_resp[grant]=1, all other ch_resp bits=0, ch_rdata=pmem_rdata. At the clock edge: state goes to IDLE, rr_ptr = grant+1 modulo NUM_CH.
- ch_resp and ch_rdata are combinational from pmem_resp and pmem_rdata.
- ch_rdata equals pmem_rdata at all times. Only the channel whose ch_resp bit is set may sample it.
- Latency:
  - Request seen in IDLE at edge N -> pmem_read/write high from cycle N+1.
  - Minimum arbiter overhead is 1 cycle per transaction.
  - Back-to-back requests: one IDLE cycle occurs between the pmem_resp cycle and the next pmem_read/write assertion.
- Fairness: after channel k completes, every other requesting channel is served before k is served again. Worst-case wait is (NUM_CH-1) transactions.
- Requester changes after grant: changes to ch_address, ch_wdata or ch_read/ch_write after grant have no effect on the in-flight transaction.
- Requester drops a request before resp (protocol violation): the latched transaction still completes and ch_resp still pulses.
- pmem_resp while in IDLE: ignored; no ch_resp is generated and the state does not change.
- Reset mid-BUSY: the FSM returns to IDLE and pmem_read/pmem_write deassert in the cycle after rst is sampled. The outstanding transaction is abandoned, no ch_resp is generated, and rr_ptr=0.
- rr_ptr wrap: for channel NUM_CH-1, the pointer advances to 0.

Test Plan:
- Single read, NUM_CH=2: ch_read[1]=1, ch_address[1]=16'h0A40; memory responds after 5 cycles with 128'hDEAD...BEEF -> pmem_read=1 and pmem_address=16'h0A40 from the next cycle; ch_resp=2'b10 in the pmem_resp cycle with ch_rdata=128'hDEAD...BEEF; pmem_read=0 in the following cycle.
- Simultaneous requests, NUM_CH=2, after reset: ch0 reads 16'h0100, ch1 writes 16'h0200 with wdata 128'h1 -> ch0 is served first, then after one IDLE cycle pmem_write=1 with pmem_address=16'h0200 and pmem_wdata=128'h1; ch_resp sequence is 01 then 10.
- Fairness, NUM_CH=4: all 4 channels hold requests continuously and each re-requests immediately after its resp -> grant order is 0,1,2,3,0,1,... with no channel served twice within any 4 consecutive transactions.
- Stable latch: ch0 is granted for address 16'h0300, then ch_address[0] changes to 16'h0FF0 while BUSY -> pmem_address stays 16'h0300 until pmem_resp.
- Stray resp: pmem_resp=1 pulsed while in IDLE with no requests -> ch_resp stays 0 and the state stays IDLE.
- Reset mid-operation: rst=1 for 1 cycle while BUSY on ch2 -> pmem_read=0 the next cycle, no ch_resp pulse, and the next simultaneous request set is granted starting from ch0.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter that funnels NUM_CH line-granular pmem-style requesters onto a
// single physical-memory port; the winning request is captured at grant time.
module pmem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic                     pmem_resp,
  input  logic [LINE_W-1:0]        pmem_rdata
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W:0]   NUM_CH_EXT = (PTR_W+1)'(NUM_CH);
  localparam logic [PTR_W-1:0] LAST_CH    = PTR_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e              state_r, state_nxt_s;
  logic [PTR_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [PTR_W-1:0]    grant_r, grant_nxt_s;
  logic                op_rd_r, op_rd_nxt_s;
  logic                op_wr_r, op_wr_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [LINE_W-1:0]   wdata_r, wdata_nxt_s;

  logic [NUM_CH-1:0]   req_s;
  logic [2*NUM_CH-1:0] req_dbl_s;
  logic [NUM_CH-1:0]   rot_req_s;
  logic                any_req_s;
  logic [PTR_W-1:0]    off_s;
  logic [PTR_W:0]      sel_sum_s;
  logic [PTR_W-1:0]    sel_s;
  logic                sel_wr_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [LINE_W-1:0]   sel_wdata_s;
  logic [NUM_CH-1:0]   ch_resp_s;

  // Rotating the request vector by rr_ptr turns round-robin into a lowest-bit search.
  assign req_s     = ch_read | ch_write;
  assign any_req_s = |req_s;
  assign req_dbl_s = {req_s, req_s} >> rr_ptr_r;
  assign rot_req_s = req_dbl_s[NUM_CH-1:0];

  // Distance from rr_ptr to the first requesting channel.
  always_comb begin
    off_s = {PTR_W{1'b0}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      off_s = rot_req_s[i] ? PTR_W'(i) : off_s;
    end
  end

  assign sel_sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
  assign sel_s     = (sel_sum_s >= NUM_CH_EXT) ? PTR_W'(sel_sum_s - NUM_CH_EXT)
                                               : sel_sum_s[PTR_W-1:0];

  // Request fields of the selected channel; write wins when both strobes are high.
  always_comb begin
    sel_wr_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {LINE_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_wr_s    = (sel_s == PTR_W'(i)) ? ch_write[i] : sel_wr_s;
      sel_addr_s  = (sel_s == PTR_W'(i)) ? ch_address[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_wdata_s = (sel_s == PTR_W'(i)) ? ch_wdata[i*LINE_W +: LINE_W] : sel_wdata_s;
    end
  end

  // Next-state, latch and completion decode.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    grant_nxt_s  = grant_r;
    op_rd_nxt_s  = op_rd_r;
    op_wr_nxt_s  = op_wr_r;
    addr_nxt_s   = addr_r;
    wdata_nxt_s  = wdata_r;
    ch_resp_s    = {NUM_CH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_BUSY;
          grant_nxt_s = sel_s;
          op_wr_nxt_s = sel_wr_s;
          op_rd_nxt_s = ~sel_wr_s;
          addr_nxt_s  = sel_addr_s;
          wdata_nxt_s = sel_wdata_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (pmem_resp) begin
          ch_resp_s    = NUM_CH'(1) << grant_r;
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = (grant_r == LAST_CH) ? {PTR_W{1'b0}} : grant_r + PTR_W'(1);
          op_rd_nxt_s  = 1'b0;
          op_wr_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        op_rd_nxt_s = 1'b0;
        op_wr_nxt_s = 1'b0;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= {PTR_W{1'b0}};
      grant_r  <= {PTR_W{1'b0}};
      op_rd_r  <= 1'b0;
      op_wr_r  <= 1'b0;
      addr_r   <= {ADDR_W{1'b0}};
      wdata_r  <= {LINE_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_r  <= grant_nxt_s;
      op_rd_r  <= op_rd_nxt_s;
      op_wr_r  <= op_wr_nxt_s;
      addr_r   <= addr_nxt_s;
      wdata_r  <= wdata_nxt_s;
    end
  end

  assign pmem_read    = op_rd_r;
  assign pmem_write   = op_wr_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;
  assign ch_resp      = ch_resp_s;
  assign ch_rdata     = pmem_rdata;

  pmem_arbiter_chk #(.NUM_CH(NUM_CH)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .ch_read  (ch_read),
    .ch_write (ch_write),
    .ch_resp  (ch_resp_s)
  );

endmodule

// Protocol checks on the requester side of the arbiter.
module pmem_arbiter_chk #(
  parameter int NUM_CH = 2
) (
  input logic              clk,
  input logic              rst,
  input logic [NUM_CH-1:0] ch_read,
  input logic [NUM_CH-1:0] ch_write,
  input logic [NUM_CH-1:0] ch_resp
);

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
    ((ch_read & ch_write) == {NUM_CH{1'b0}}));

  a_resp_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(ch_resp));

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter (4 channels): a transaction-level model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_pmem_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int LW  = 128;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_read;
  logic [NCH-1:0]    ch_write;
  logic [NCH*AW-1:0] ch_address;
  logic [NCH*LW-1:0] ch_wdata;
  logic [NCH-1:0]    ch_resp;
  logic [LW-1:0]     ch_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [AW-1:0]     pmem_address;
  logic [LW-1:0]     pmem_wdata;
  logic              pmem_resp;
  logic [LW-1:0]     pmem_rdata;

  int   total = 0;
  int   bad   = 0;
  logic chk_en = 1'b0;

  // transaction-level model of the arbiter
  logic           m_busy, m_rd, m_wr;
  int             m_gnt, m_rr;
  logic [AW-1:0]  m_addr;
  logic [LW-1:0]  m_wdata;
  logic [NCH-1:0] m_req;

  int             order [8];
  logic [NCH-1:0] rv;

  pmem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_read      (ch_read),
    .ch_write     (ch_write),
    .ch_address   (ch_address),
    .ch_wdata     (ch_wdata),
    .ch_resp      (ch_resp),
    .ch_rdata     (ch_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // first requesting channel at or after rr, searching upward modulo NCH
  function automatic int pick(input logic [NCH-1:0] req, input int rr);
    int c;
    for (int k = 0; k < NCH; k++) begin
      c = (rr + k) % NCH;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < NCH; k++) begin
      if (v[k]) r = (r == -1) ? k : -2;
    end
    return r;
  endfunction

  assign m_req = ch_read | ch_write;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_gnt   <= 0;
      m_rr    <= 0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy <= 1'b0;
        m_rr   <= (m_gnt + 1) % NCH;
      end
    end else if (pick(m_req, m_rr) >= 0) begin
      m_busy  <= 1'b1;
      m_gnt   <= pick(m_req, m_rr);
      m_wr    <= ch_write[pick(m_req, m_rr)];
      m_rd    <= !ch_write[pick(m_req, m_rr)];
      m_addr  <= ch_address[pick(m_req, m_rr)*AW +: AW];
      m_wdata <= ch_wdata[pick(m_req, m_rr)*LW +: LW];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_pmem_read",    pmem_read,    m_busy & m_rd);
      check("mdl_pmem_write",   pmem_write,   m_busy & m_wr);
      check("mdl_pmem_address", pmem_address, m_addr);
      check("mdl_pmem_wdata",   pmem_wdata,   m_wdata);
      check("mdl_ch_resp",      ch_resp,      (m_busy && pmem_resp) ? (4'b0001 << m_gnt) : 4'b0000);
      check("mdl_ch_rdata",     ch_rdata,     pmem_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Memory side: wait for a request, respond after lat edges, return the ch_resp seen.
  task automatic serve(input int lat, input logic [LW-1:0] data, output logic [NCH-1:0] resp_seen);
    int n;
    n = 0;
    resp_seen = '0;
    while (!(pmem_read | pmem_write) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL mem_wait: no pmem request within 40 cycles");
    end else begin
      repeat (lat) @(posedge clk);
      #1;
      pmem_resp  = 1'b1;
      pmem_rdata = data;
      @(negedge clk);
      resp_seen = ch_resp;
      check("resp_rdata", ch_rdata, data);
      tick();
      pmem_resp = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] seen;
    rst        = 1'b1;
    ch_read    = '0;
    ch_write   = '0;
    ch_address = '0;
    ch_wdata   = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_pmem_read",  pmem_read,    1'b0);
    check("rst_pmem_write", pmem_write,   1'b0);
    check("rst_ch_resp",    ch_resp,      4'b0000);
    check("rst_address",    pmem_address, 16'h0000);

    // single read on ch1
    ch_address[1*AW +: AW] = 16'h0A40;
    ch_read[1] = 1'b1;
    @(negedge clk);
    check("rd1_pmem_read", pmem_read,    1'b1);
    check("rd1_address",   pmem_address, 16'h0A40);
    serve(5, 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF, rv);
    check("rd1_ch_resp", rv, 4'b0010);
    ch_read[1] = 1'b0;
    @(negedge clk);
    check("rd1_read_drop", pmem_read, 1'b0);

    // simultaneous read on ch0 and write on ch1 after reset
    do_reset();
    ch_address[0*AW +: AW] = 16'h0100;
    ch_read[0]             = 1'b1;
    ch_address[1*AW +: AW] = 16'h0200;
    ch_wdata[1*LW +: LW]   = 128'h1;
    ch_write[1]            = 1'b1;
    serve(2, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, rv);
    check("sim_first_resp", rv, 4'b0001);
    ch_read[0] = 1'b0;
    @(negedge clk);
    check("sim_idle_gap", {pmem_read, pmem_write}, 2'b00);
    @(negedge clk);
    check("sim_pmem_write", pmem_write,   1'b1);
    check("sim_address",    pmem_address, 16'h0200);
    check("sim_wdata",      pmem_wdata,   128'h1);
    serve(3, 128'h0, rv);
    check("sim_second_resp", rv, 4'b0010);
    ch_write[1] = 1'b0;

    // fairness with all four channels requesting continuously
    @(negedge clk);
    do_reset();
    for (int i = 0; i < NCH; i++) ch_address[i*AW +: AW] = 16'h1000 + 16'(i);
    ch_read = 4'hF;
    for (int t = 0; t < 8; t++) begin
      serve(1 + (t % 3), {96'h0, 32'(t)}, rv);
      order[t] = oh_idx(rv);
    end
    ch_read = 4'h0;
    for (int t = 0; t < 8; t++) check("fair_order", 128'(order[t]), 128'(t % 4));
    for (int w = 0; w < 5; w++) begin
      seen = '0;
      for (int j = 0; j < NCH; j++) begin
        if (order[w+j] >= 0) seen[order[w+j]] = 1'b1;
      end
      check("fair_window", seen, 4'hF);
    end

    // latched address survives requester changes while busy
    @(negedge clk);
    ch_address[0*AW +: AW] = 16'h0300;
    ch_read[0] = 1'b1;
    @(negedge clk);
    check("latch_grant",   pmem_read,    1'b1);
    check("latch_address", pmem_address, 16'h0300);
    ch_address[0*AW +: AW] = 16'h0FF0;
    @(negedge clk);
    @(negedge clk);
    check("latch_hold", pmem_address, 16'h0300);
    serve(4, 128'h5A5A, rv);
    check("latch_resp", rv, 4'b0001);
    ch_read[0] = 1'b0;

    // stray pmem_resp while idle
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 128'hFFFF;
    @(negedge clk);
    check("stray_ch_resp", ch_resp, 4'b0000);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    check("stray_idle", {pmem_read, pmem_write}, 2'b00);

    // reset while busy on ch2, then all channels request
    tick();
    ch_address[2*AW +: AW] = 16'h0222;
    ch_read[2] = 1'b1;
    tick();
    @(negedge clk);
    check("rstb_grant",   pmem_read,    1'b1);
    check("rstb_address", pmem_address, 16'h0222);
    rst     = 1'b1;
    ch_read = 4'hF;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstb_read_low", pmem_read, 1'b0);
    check("rstb_no_resp",  ch_resp,   4'b0000);
    @(negedge clk);
    check("rstb_regrant",  pmem_read,    1'b1);
    check("rstb_ch0_addr", pmem_address, 16'h0FF0);
    serve(2, 128'h77, rv);
    check("rstb_ch0_first", rv, 4'b0001);
    ch_read = 4'h0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
